// File: rtl/apexii_ddio_in_burst_ctrl_if.sv
// Capture-side bundle between the burst controller, the DDIO input atom and the word consumer.
// master = controller side, slave = environment (atom model, requester, consumer).
// Widths follow the controller's WORD_WIDTH / LEN_WIDTH parameters.
interface apexii_ddio_in_burst_ctrl_if #(
    parameter int WORD_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  busy;
    logic                  done;
    logic                  ddio_clkena;
    logic                  ddio_h;
    logic                  ddio_l;
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        input  start, burst_len, ddio_h, ddio_l, word_ready,
        output busy, done, ddio_clkena, word_data, word_valid
    );

    modport slave (
        output start, burst_len, ddio_h, ddio_l, word_ready,
        input  busy, done, ddio_clkena, word_data, word_valid
    );
endinterface

// File: rtl/apexii_ddio_in_burst_ctrl.sv
// Burst capture controller: gates the DDIO input atom clock enable and packs h/l pairs into words.
// Latency: first enable 1 cycle after start, first word valid PAIRS+2 cycles after start.
// Backpressure: the last pair of a word is withheld until the single-entry output register is free.
module apexii_ddio_in_burst_ctrl #(
    parameter int WORD_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic clk,
    input  logic sreset,
    apexii_ddio_in_burst_ctrl_if.master bus
);
    localparam int PAIRS = WORD_WIDTH / 2;
    localparam int PCW   = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [PCW-1:0]        pair_cnt;
    logic [PCW-1:0]        cap_cnt;
    logic [LEN_WIDTH-1:0]  words_left;
    logic                  last_inflight;
    logic                  cap_pending;
    logic [WORD_WIDTH-1:0] sh;
    logic [WORD_WIDTH-1:0] sh_nxt;
    logic                  clkena;
    logic                  zero_start;
    logic                  final_hs;
    logic                  accept;
    logic                  last_pair;
    logic                  last_word;
    logic                  handshake;
    logic                  word_done;

    assign last_pair = (pair_cnt == PCW'(PAIRS - 1));
    assign last_word = (words_left == LEN_WIDTH'(1));
    assign handshake = bus.word_valid && bus.word_ready;
    assign word_done = cap_pending && (cap_cnt == PCW'(PAIRS - 1));
    assign accept    = (state == IDLE) && bus.start && (bus.burst_len != '0);

    // Newest pair enters at the top, so pair 0 ends up in the low bits.
    generate
        if (WORD_WIDTH == 2) begin : g_min
            assign sh_nxt = {bus.ddio_h, bus.ddio_l};
        end else begin : g_wide
            assign sh_nxt = {bus.ddio_h, bus.ddio_l, sh[WORD_WIDTH-1:2]};
        end
    endgenerate

    always_comb begin
        state_nxt  = state;
        clkena     = 1'b0;
        zero_start = 1'b0;
        final_hs   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.burst_len != '0) state_nxt = RUN;
                    else                     zero_start = 1'b1;
                end
            end
            RUN: begin
                // A last pair completes a word one cycle after capture; it may only be
                // issued if the output register will be empty by then.
                clkena = !last_pair || (!last_inflight && (!bus.word_valid || bus.word_ready));
                if (clkena && last_pair && last_word) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (handshake) begin
                    final_hs  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (sreset) clkena = 1'b0;
    end

    assign bus.ddio_clkena = clkena;
    assign bus.busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (sreset) begin
            state          <= IDLE;
            pair_cnt       <= '0;
            cap_cnt        <= '0;
            words_left     <= '0;
            last_inflight  <= 1'b0;
            cap_pending    <= 1'b0;
            sh             <= '0;
            bus.word_data  <= '0;
            bus.word_valid <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.done      <= zero_start || final_hs;
            last_inflight <= clkena && last_pair;
            cap_pending   <= clkena;

            if (accept) begin
                words_left <= bus.burst_len;
                pair_cnt   <= '0;
            end else if (clkena) begin
                if (last_pair) begin
                    pair_cnt   <= '0;
                    words_left <= words_left - LEN_WIDTH'(1);
                end else begin
                    pair_cnt   <= pair_cnt + PCW'(1);
                end
            end

            if (cap_pending) begin
                sh      <= sh_nxt;
                cap_cnt <= word_done ? '0 : cap_cnt + PCW'(1);
            end

            if (word_done) begin
                bus.word_data  <= sh_nxt;
                bus.word_valid <= 1'b1;
            end else if (handshake) begin
                bus.word_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/apexii_ddio_in_burst_ctrl.md
# apexii_ddio_in_burst_ctrl

Burst capture controller for an APEX II DDR input I/O atom in "input" ddio mode. Drives the atom's input clock enable, consumes the registered high and low bits it returns, assembles them into `WORD_WIDTH`-bit words, and hands each word downstream through a single-entry valid/ready output register. The block sits between the DDIO input cell and the core-side consumer. It throttles capture so that no returned bit is ever dropped.

## Interface
- `WORD_WIDTH`, 8: output word width. Must be even and ≥2. `PAIRS = WORD_WIDTH/2` atom cycles per word.
- `LEN_WIDTH`, 8: width of the burst length, in words.

- `clk`  in  1  single clock. Shared with the DDIO atom's `inclk`.
- `sreset`  in  1  synchronous, active-high reset.
- `start`  in  1  burst request. Sampled only in IDLE.
- `burst_len`  in  LEN_WIDTH  words to capture. Sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted nonzero start until the final word handshake.
- `done`  out  1  one-cycle completion pulse.
- `ddio_clkena`  out  1  drives the atom's `inclkena`.
- `ddio_h`  in  1  atom high-register output.
- `ddio_l`  in  1  atom low-register output.
- `word_data`  out  WORD_WIDTH  assembled word.
- `word_valid`  out  1  `word_data` holds an unconsumed word.
- `word_ready`  in  1  downstream accepts a word when both `word_valid` and `word_ready` are high.

## Operation
- **States:**
  - IDLE → RUN: on `start` with `burst_len != 0`. Load `words_left = burst_len` and `pair_cnt = 0`.
  - IDLE, zero-length start: if `start` and `burst_len == 0`, pulse `done` the next cycle and stay in IDLE. `busy` stays low.
  - RUN → DRAIN: when the enable for the last pair of the last word is issued.
  - DRAIN → IDLE: at the edge where the final word handshakes.
- **`start` while busy:** `start` in RUN or DRAIN is ignored and has no effect.
- **Enable rule:** `ddio_clkena` is combinational and is high only in RUN.
  - Non-last pair of a word (`pair_cnt < PAIRS-1`): enable unconditionally.
  - Last pair: enable only if `!last_inflight && (!word_valid || word_ready)`.
  - `last_inflight` is a register set in the cycle after a last-pair enable.
  - Each issued enable advances `pair_cnt`. `pair_cnt` wraps to 0 after the last pair, and `words_left` decrements at that point.
- **Capture tracking:** the atom latency is one cycle, so `cap_pending <= ddio_clkena`. On every edge where `cap_pending` is set, the controller consumes `ddio_h` and `ddio_l`.
- **Assembly:** shift register `sh <= {ddio_h, ddio_l, sh[W-1:2]}`.
  - Pair k (0 = first) ends up at bits [2k+1:2k], with h in the upper bit of the pair.
  - On the consumed pair that completes a word, the value `{ddio_h, ddio_l, sh[W-1:2]}` loads directly into `word_data` and sets `word_valid`.
- **Output register:** the enable rule guarantees the register is free on every load.
  - `word_valid` clears on handshake unless a new word loads at the same edge. In that case it stays high with the new data.
- **`done`:** pulses in the cycle after the final word's handshake edge. `busy` goes low in that same cycle.
- **`sreset`:** synchronous, and overrides everything including mid-burst.
  - State goes to IDLE. All counters and `cap_pending`/`last_inflight` clear. `word_valid` and `word_data` go to 0.
  - `ddio_clkena` is forced low combinationally while `sreset` is high.
  - A pair returning from the atom after reset is discarded, because `cap_pending` is already 0.

## Timing
- **Reset values:** `busy`=0, `done`=0, `word_valid`=0, `word_data`=0, `ddio_clkena`=0.
- **Start latency:**
  - `start` accepted at edge of cycle t; `ddio_clkena` first high in cycle t+1.
  - First pair visible on `ddio_h`/`ddio_l` in cycle t+2.
  - First word valid in cycle t+1+PAIRS+1 when unstalled.
- **Throughput, `PAIRS ≥ 2` with `word_ready` held high:** one pair per cycle and no gaps. Enable is continuous for `burst_len*PAIRS` cycles.
- **Throughput, `PAIRS == 1`:** one word per 2 cycles, limited by `last_inflight`.
- **Stall:** with `word_ready` low and `word_valid` high, enable stops after `PAIRS-1` pairs of the next word. Enable resumes in the same cycle `word_ready` rises.
- **Max burst:** `2^LEN_WIDTH - 1` words. Counters never wrap within a burst.

## Test plan
- **Unstalled burst.** W=8, `burst_len`=3, `word_ready`=1, h/l pattern giving words 0xA5, 0x3C, 0xFF. Required:
  - `ddio_clkena` high for exactly 12 consecutive cycles starting the cycle after `start`.
  - Words arrive in order with `word_valid` one cycle each.
  - `done` pulses once, the cycle after the third handshake.
- **Backpressure.** W=8, `burst_len`=2, `word_ready`=0 until 10 cycles after the first word. Required:
  - Exactly 3 pairs of word 1 issued, then `ddio_clkena` held low.
  - Word 0 held stable throughout.
  - After `word_ready` rises, one enable, then word 1 valid 2 cycles later. No bit lost.
- **Zero-length burst.** `burst_len`=0 → `done` pulses 1 cycle later; `busy` and `ddio_clkena` never high.
- **Start while busy.** Second `start` with `burst_len`=5 during a 2-word burst → exactly 2 words delivered; `done` pulses once.
- **Reset mid-burst.** `sreset` pulsed for one cycle mid-word → next cycle all outputs at reset values. A new `start` afterwards delivers correct words with no leftover bits.
- **Minimum word width.** W=2, `burst_len`=4, `word_ready`=1 → `ddio_clkena` toggles high every other cycle, 4 words, `done` once.
